// File: rtl/bias_conv2_seq.sv
// bias_conv2_seq: walks conv2 output batches, fetches one bias word per batch from ROM and holds it for PIX_PER_BATCH pixels
module bias_conv2_seq #(
   parameter int OUTPUT_BATCH  = 1,
   parameter int OUTPUT_NUM    = 16,
   parameter int WDP_BIAS      = 34,
   parameter int PIX_PER_BATCH = 100,
   parameter int W_ADDR        = 1,
   parameter int W_PIX         = 7
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [W_ADDR-1:0]              rom_aa,
   output logic                           rom_cena,
   input  logic [WDP_BIAS*OUTPUT_NUM-1:0] rom_qa,
   input  logic                           pix_done,
   output logic [WDP_BIAS*OUTPUT_NUM-1:0] bias_vec,
   output logic                           bias_valid,
   output logic [W_ADDR-1:0]              batch_idx
);
   localparam logic [W_PIX-1:0]  PIX_LAST   = W_PIX'(PIX_PER_BATCH - 1);
   localparam logic [W_ADDR-1:0] BATCH_LAST = W_ADDR'(OUTPUT_BATCH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, RUN, DONE} state_t;

   state_t                          state_q;
   logic                            busy_q, done_q, err_q, cena_q, valid_q;
   logic [W_ADDR-1:0]               aa_q, batch_q;
   logic [W_PIX-1:0]                cnt_q;
   logic [WDP_BIAS*OUTPUT_NUM-1:0]  vec_q;
   logic                            err_d;
   logic [W_ADDR-1:0]               batch_d;

   // accepted start clears err; a stray pixel outside RUN sets it in the same cycle
   always_comb begin
      err_d   = ((state_q == IDLE && start) ? 1'b0 : err_q) | (pix_done & ~valid_q);
      batch_d = batch_q + W_ADDR'(1);
   end

   // sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cena_q  <= 1'b1;
         valid_q <= 1'b0;
         aa_q    <= '0;
         batch_q <= '0;
         cnt_q   <= '0;
         vec_q   <= '0;
      end else begin
         err_q <= err_d;
         case (state_q)
            IDLE: if (start) begin
               busy_q  <= 1'b1;
               batch_q <= '0;
               aa_q    <= '0;
               cena_q  <= 1'b0;
               state_q <= FETCH;
            end
            FETCH: begin
               cena_q  <= 1'b1;
               state_q <= LATCH;
            end
            LATCH: begin
               vec_q   <= rom_qa;
               cnt_q   <= '0;
               valid_q <= 1'b1;
               state_q <= RUN;
            end
            RUN: if (pix_done) begin
               if (cnt_q == PIX_LAST) begin
                  valid_q <= 1'b0;
                  if (batch_q == BATCH_LAST) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     batch_q <= batch_d;
                     aa_q    <= batch_d;
                     cena_q  <= 1'b0;
                     state_q <= FETCH;
                  end
               end else begin
                  cnt_q <= cnt_q + W_PIX'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign rom_aa     = aa_q;
   assign rom_cena   = cena_q;
   assign bias_vec   = vec_q;
   assign bias_valid = valid_q;
   assign batch_idx  = batch_q;
endmodule

// File: tb/tb_bias_conv2_seq.sv
// tb_bias_conv2_seq: randomized scoreboard bench for bias_conv2_seq against a behavioural ROM/batch model
module tb_bias_conv2_seq;
   localparam int OB = 3;
   localparam int ON = 16;
   localparam int WB = 34;
   localparam int PIX = 4;
   localparam int WA = 2;
   localparam int WP = 3;
   localparam int W = WB * ON;

   typedef struct {
      bit           is_done;
      int           b;
      logic [W-1:0] v;
   } exp_t;

   logic          clk, rstn, start, pix_done;
   logic          busy, done, err, rom_cena, bias_valid;
   logic [WA-1:0] rom_aa, batch_idx;
   logic [W-1:0]  rom_qa, bias_vec;
   logic [W-1:0]  rom [0:3];

   exp_t q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   bit   prev_bv = 0;
   int   gap = 0, pcnt = 0, reads = 0;

   bias_conv2_seq #(
      .OUTPUT_BATCH(OB), .OUTPUT_NUM(ON), .WDP_BIAS(WB),
      .PIX_PER_BATCH(PIX), .W_ADDR(WA), .W_PIX(WP)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
      .rom_aa(rom_aa), .rom_cena(rom_cena), .rom_qa(rom_qa), .pix_done(pix_done),
      .bias_vec(bias_vec), .bias_valid(bias_valid), .batch_idx(batch_idx)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // ROM: data valid the cycle after a sampled read, garbage otherwise
   always @(posedge clk) rom_qa <= !rom_cena ? rom[rom_aa] : rnd();

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rom();
      for (int b = 0; b < 4; b++) rom[b] = rnd();
   endtask

   task automatic do_start(input bit with_pix);
      start = 1;
      pix_done = with_pix;
      for (int b = 0; b < OB; b++) q.push_back('{0, b, rom[b]});
      q.push_back('{1, 0, '0});
      tick();
      start = 0;
      pix_done = 0;
   endtask

   task automatic finish_pass(input int mode);
      int n = 0;
      while (!done && n < 300) begin
         pix_done = bias_valid && (mode == 1 || $urandom_range(0, 1) == 1);
         tick();
         n++;
      end
      pix_done = 0;
      chk("pass_done_seen", done, 1);
      tick();
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
   endtask

   // monitor: pops expected batch words and done tokens as the DUT presents them
   always @(negedge clk) begin
      if (!rstn) begin
         q.delete();
         prev_bv = 0;
         gap = 0;
         pcnt = 0;
         reads = 0;
      end else begin
         if (!rom_cena) reads++;
         if (bias_valid && !prev_bv) begin
            if (q.size() == 0 || q[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL sb_batch: got batch %0d presented, expected none", batch_idx);
            end else begin
               cur = q.pop_front();
               chk("sb_idx", W'(batch_idx), W'(cur.b));
               chk("sb_vec", bias_vec, cur.v);
               if (cur.b != 0) chk("sb_gap", W'(gap), W'(2));
            end
            gap = 0;
            pcnt = 0;
         end
         if (bias_valid && pix_done) pcnt++;
         if (!bias_valid && prev_bv) begin
            chk("sb_pix", W'(pcnt), W'(PIX));
            chk("sb_hold", bias_vec, cur.v);
         end
         if (!bias_valid) gap++;
         if (done) begin
            if (q.size() > 0 && q[0].is_done) begin
               void'(q.pop_front());
               chk("sb_reads", W'(reads), W'(OB));
               chk("sb_done_lat", W'(prev_bv), W'(1));
            end else begin
               checks++;
               errors++;
               $display("FAIL sb_done: got unexpected done, expected none (queue %0d)", q.size());
            end
            reads = 0;
         end
         prev_bv = bias_valid;
      end
   end

   initial begin
      int bad, n;
      rstn = 0;
      start = 0;
      pix_done = 0;
      fill_rom();
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_valid", bias_valid, 0);
      chk("rst_vec", bias_vec, 0);
      chk("rst_idx", batch_idx, 0);
      chk("rst_cena", rom_cena, 1);
      chk("rst_aa", rom_aa, 0);
      rstn = 1;
      bad = 0;
      repeat (10) begin
         tick();
         if (rom_cena !== 1 || busy !== 0 || done !== 0 || bias_vec !== '0) bad++;
      end
      chk("idle_quiet", W'(bad), 0);

      // pass with signed test-plan words and random pixel pacing, latency checked
      rom[0][W-1 -: WB] = -34'sd167012672;
      rom[0][WB-1:0]    = -34'sd141673920;
      do_start(0);
      chk("lat_cena_n1", rom_cena, 0);
      chk("lat_aa_n1", rom_aa, 0);
      chk("lat_busy_n1", busy, 1);
      chk("lat_valid_n1", bias_valid, 0);
      tick();
      chk("lat_cena_n2", rom_cena, 1);
      chk("lat_valid_n2", bias_valid, 0);
      tick();
      chk("lat_valid_n3", bias_valid, 1);
      chk("lat_vec_n3", bias_vec, rom[0]);
      finish_pass(0);

      // continuous pix_done
      fill_rom();
      do_start(0);
      finish_pass(1);

      // protocol violations: pix_done in FETCH, start in RUN
      fill_rom();
      do_start(0);
      pix_done = 1;
      tick();
      pix_done = 0;
      chk("err_fetch_pix", err, 1);
      tick();
      chk("err_run_valid", bias_valid, 1);
      start = 1;
      tick();
      start = 0;
      chk("err_sticky", err, 1);
      chk("start_busy_ignored", busy, 1);
      finish_pass(0);
      chk("err_after_pass", err, 1);
      fill_rom();
      do_start(0);
      chk("err_cleared", err, 0);
      finish_pass(1);
      do_start(1);
      chk("err_start_and_pix", err, 1);
      finish_pass(0);

      // reset in RUN of batch 1
      fill_rom();
      do_start(0);
      n = 0;
      while (!(batch_idx == 1 && bias_valid) && n < 100) begin
         pix_done = bias_valid;
         tick();
         n++;
      end
      pix_done = 0;
      chk("reach_batch1", W'(batch_idx), 1);
      rstn = 0;
      tick();
      chk("mid_rst_valid", bias_valid, 0);
      chk("mid_rst_vec", bias_vec, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_idx", batch_idx, 0);
      chk("mid_rst_cena", rom_cena, 1);
      rstn = 1;
      bad = 0;
      repeat (5) begin
         tick();
         if (done !== 0 || busy !== 0) bad++;
      end
      chk("mid_rst_no_done", W'(bad), 0);
      fill_rom();
      do_start(0);
      chk("restart_aa", rom_aa, 0);
      chk("restart_cena", rom_cena, 0);
      finish_pass(1);

      repeat (3) tick();
      chk("sb_empty", W'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
